wb_mem_tester: RTL and testbench
================================

# wb_mem_tester

Wishbone bus initiator that exercises the SDRAM controller's Wishbone slave port. On `start` it writes an address-derived pattern over an inclusive word range, reads the range back, compares each word and reports pass/fail, the error count and the first failing location. It sits between board-level bring-up logic (switches/LEDs or a debug core) and the SDRAM controller, and is used for memory bring-up and soak testing.

## Interface
- `ADDR_W`, 23, Wishbone word-address width; must be ≤ `DATA_W`.
- `DATA_W`, 32, Wishbone data width.
- `TIMEOUT_CYC`, 1023, maximum cycles `stb_o` is held without `ack_i` (used only with the timeout feature).

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  single-cycle run request; sampled only in IDLE.
- `addr_lo`  in  ADDR_W  first word address; latched on `start`.
- `addr_hi`  in  ADDR_W  last word address (inclusive); latched on `start`.
- `seed`  in  DATA_W  pattern seed; latched on `start`.
- `busy`  out  1  run in progress.
- `done`  out  1  run finished; held until the next accepted `start` or `rst`.
- `pass`  out  1  valid while `done`=1; 1 means no mismatch, no range error and no timeout.
- `timeout`  out  1  run aborted because `ack_i` did not arrive.
- `err_count`  out  16  number of mismatching read words; saturates at 0xFFFF.
- `first_err_addr`  out  ADDR_W  address of the first mismatch.
- `first_err_data`  out  DATA_W  data read at the first mismatch.
- `cyc_o`, `stb_o`, `we_o`  out  1  Wishbone master controls.
- `addr_o`  out  ADDR_W  Wishbone address.
- `dat_o`  out  DATA_W  Wishbone write data.
- `dat_i`  in  DATA_W  Wishbone read data.
- `ack_i`  in  1  Wishbone acknowledge.

## Operation
- All outputs are registered. Every output resets to 0.
- Pattern: `pat(a) = seed_r ^ zero_extend(a)`.
- States:
  - IDLE: waits for `start`.
  - CHK: range check.
  - WR_REQ: write request in flight.
  - WR_GAP: gap after a write.
  - RD_REQ: read request in flight.
  - RD_GAP: gap after a read.
  - FIN: run complete.
- IDLE + `start` → CHK.
  - In the same edge: latch the inputs, clear `done`, `pass`, `timeout`, `err_count`, `first_err_*`, and set `busy`=1.
- CHK:
  - If `addr_lo_r` > `addr_hi_r` → FIN with `pass`=0 (range error); no bus cycle is issued.
  - Otherwise `cur` = `addr_lo_r` and → WR_REQ.
- WR_REQ: drive `cyc_o`=`stb_o`=`we_o`=1, `addr_o`=`cur`, `dat_o`=`pat(cur)`.
  - Hold them until `ack_i`=1 is sampled, then → WR_GAP.
  - `cyc_o`/`stb_o` drop on the next edge.
- WR_GAP: wait until `ack_i`=0.
  - If `cur`==`addr_hi_r`: reset `cur` to `addr_lo_r` and → RD_REQ.
  - Otherwise increment `cur` and → WR_REQ.
- RD_REQ: same handshake as WR_REQ with `we_o`=0.
  - On the `ack_i` sample edge, compare `dat_i` with `pat(cur)`.
  - On mismatch: increment `err_count` (saturating). If it was 0, capture `first_err_addr`=`cur` and `first_err_data`=`dat_i`.
  - → RD_GAP.
- RD_GAP: wait until `ack_i`=0.
  - If `cur`==`addr_hi_r` → FIN.
  - Otherwise increment `cur` and → RD_REQ.
- FIN: `busy`=0, `done`=1, `pass` set as defined under Interface; → IDLE.
- `start` while `busy`=1 is ignored.
- A multi-cycle `ack_i` counts as exactly one transfer.
- `addr_hi` = all-ones is legal. The loop ends on equality, so `cur` never wraps.
- `rst` mid-run: all state and outputs return to reset values at that edge, and `cyc_o`/`stb_o` are low from the following cycle.

## Timing
- `start` sampled at edge t:
  - `busy`=1 after t.
  - First `cyc_o`/`stb_o` high after t+2 (CHK takes one cycle).
- `ack_i` sampled high at edge n: `stb_o`/`cyc_o` low after n.
- `ack_i` first sampled low at edge m (m > n): the next request is driven after m+1 (one state-transition cycle).
- Minimum per-word cost is the request-to-ack latency + 2 cycles.
- `err_count` and `first_err_*` update at the `ack_i` sample edge of the failing read.
- `done`/`pass` assert 1 cycle after the last read's gap exits.
- Range error: `done`=1 after t+2 and `pass`=0.

## Configuration
- Macro `WB_MEM_TESTER_TIMEOUT_EN`.
- Defined:
  - A watchdog counts cycles in WR_REQ/RD_REQ with `ack_i`=0 and clears on each new request.
  - On reaching `TIMEOUT_CYC` it drops `cyc_o`/`stb_o` and goes to FIN with `timeout`=1 and `pass`=0.
- Undefined: no watchdog; the block waits for `ack_i` indefinitely; `timeout` is tied to 0.

## Test plan
- Range 0..3, `seed`=0xA5A50000, ideal memory model with 5-cycle ack → 4 writes of data 0xA5A50000..0xA5A50003, then 4 reads; `done`=1, `pass`=1, `err_count`=0.
- Same run, model flips bit 0 on the read of address 2 → `pass`=0, `err_count`=1, `first_err_addr`=2, `first_err_data`=0xA5A50003.
- `addr_lo`=5, `addr_hi`=4, `start` at edge t → `done`=1 and `pass`=0 after t+2; `cyc_o` never asserts.
- Model holds `ack_i` high for 2 cycles per transfer, range 0..1 → exactly 2 writes and 2 reads; each new `stb_o` rises only after `ack_i` has been observed low.
- With the macro defined, `TIMEOUT_CYC`=15, model never acks → `stb_o` drops within 16 cycles, `timeout`=1, `pass`=0. Without the macro, `stb_o` stays high for 1000 cycles.
- `rst` pulsed during the third read of range 0..7 → the next cycle shows `cyc_o`=`stb_o`=0 and `busy`=`done`=0; a following `start` completes with `pass`=1.

Source files
------------

// File: rtl/wb_mem_tester_if.sv
// wb_mem_tester_if: Wishbone master-side bus bundle between the tester and the memory slave
interface wb_mem_tester_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 32
) ();
    logic              cyc_o;
    logic              stb_o;
    logic              we_o;
    logic [ADDR_W-1:0] addr_o;
    logic [DATA_W-1:0] dat_o;
    logic [DATA_W-1:0] dat_i;
    logic              ack_i;

    modport master (
        output cyc_o, stb_o, we_o, addr_o, dat_o,
        input  dat_i, ack_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, addr_o, dat_o,
        output dat_i, ack_i
    );
endinterface

// File: rtl/wb_mem_tester.sv
// wb_mem_tester: writes seed^addr over [addr_lo..addr_hi], reads it back and reports errors; ack watchdog under WB_MEM_TESTER_TIMEOUT_EN
module wb_mem_tester #(
    parameter int ADDR_W      = 23,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_lo,
    input  logic [ADDR_W-1:0] addr_hi,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    wb_mem_tester_if.master   wb
);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, CHK, WR_REQ, WR_GAP, RD_REQ, RD_GAP, FIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] lo_q, lo_d, hi_q, hi_d, cur_q, cur_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic              timeout_q, timeout_d, range_err_q, range_err_d;
    logic [15:0]       err_q, err_d;
    logic [ADDR_W-1:0] fa_q, fa_d, addr_q, addr_d;
    logic [DATA_W-1:0] fd_q, fd_d, dat_q, dat_d;
    logic              cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [DATA_W-1:0] pat;
    logic              req, to_hit;

    assign pat = seed_q ^ DATA_W'(cur_q);
    assign req = (state_q == WR_REQ) || (state_q == RD_REQ);

`ifdef WB_MEM_TESTER_TIMEOUT_EN
    logic [WD_W-1:0] wd_q, wd_d;

    // Watchdog: counts unacknowledged request cycles, cleared whenever no request is pending
    always_comb begin
        wd_d   = (req && !wb.ack_i) ? wd_q + WD_W'(1) : '0;
        to_hit = req && !wb.ack_i && (wd_q == WD_W'(TIMEOUT_CYC - 1));
    end

    // Watchdog counter register
    always_ff @(posedge clk) begin
        if (rst) wd_q <= '0;
        else     wd_q <= wd_d;
    end
`else
    logic [WD_W-1:0] wd_unused;
    assign wd_unused = '0;
    assign to_hit    = 1'b0;
`endif

    // Next-state and registered-output logic for the whole run
    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        cur_d       = cur_q;
        seed_d      = seed_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        range_err_d = range_err_q;
        err_d       = err_q;
        fa_d        = fa_q;
        fd_d        = fd_q;
        addr_d      = addr_q;
        dat_d       = dat_q;
        cyc_d       = 1'b0;
        stb_d       = 1'b0;
        we_d        = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d     = CHK;
                lo_d        = addr_lo;
                hi_d        = addr_hi;
                seed_d      = seed;
                busy_d      = 1'b1;
                done_d      = 1'b0;
                pass_d      = 1'b0;
                timeout_d   = 1'b0;
                range_err_d = 1'b0;
                err_d       = '0;
                fa_d        = '0;
                fd_d        = '0;
            end
            CHK: begin
                range_err_d = lo_q > hi_q;
                cur_d       = lo_q;
                state_d     = (lo_q > hi_q) ? FIN : WR_REQ;
            end
            WR_REQ, RD_REQ: begin
                if (to_hit) begin
                    timeout_d = 1'b1;
                    state_d   = FIN;
                end else if (stb_q && wb.ack_i) begin
                    state_d = (state_q == WR_REQ) ? WR_GAP : RD_GAP;
                    if (state_q == RD_REQ && wb.dat_i != pat) begin
                        err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
                        fa_d  = (err_q == '0) ? cur_q : fa_q;
                        fd_d  = (err_q == '0) ? wb.dat_i : fd_q;
                    end
                end else begin
                    cyc_d  = 1'b1;
                    stb_d  = 1'b1;
                    we_d   = state_q == WR_REQ;
                    addr_d = cur_q;
                    dat_d  = pat;
                end
            end
            WR_GAP: if (!wb.ack_i) begin
                cur_d   = (cur_q == hi_q) ? lo_q : cur_q + ADDR_W'(1);
                state_d = (cur_q == hi_q) ? RD_REQ : WR_REQ;
            end
            RD_GAP: if (!wb.ack_i) begin
                cur_d   = (cur_q == hi_q) ? cur_q : cur_q + ADDR_W'(1);
                state_d = (cur_q == hi_q) ? FIN : RD_REQ;
            end
            FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = !range_err_q && !timeout_q && (err_q == '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, all cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lo_q        <= '0;
            hi_q        <= '0;
            cur_q       <= '0;
            seed_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            range_err_q <= 1'b0;
            err_q       <= '0;
            fa_q        <= '0;
            fd_q        <= '0;
            addr_q      <= '0;
            dat_q       <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            cur_q       <= cur_d;
            seed_q      <= seed_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            range_err_q <= range_err_d;
            err_q       <= err_d;
            fa_q        <= fa_d;
            fd_q        <= fd_d;
            addr_q      <= addr_d;
            dat_q       <= dat_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign err_count      = err_q;
    assign first_err_addr = fa_q;
    assign first_err_data = fd_q;
    assign wb.cyc_o       = cyc_q;
    assign wb.stb_o       = stb_q;
    assign wb.we_o        = we_q;
    assign wb.addr_o      = addr_q;
    assign wb.dat_o       = dat_q;
endmodule

// File: tb/tb_wb_mem_tester.sv
// tb_wb_mem_tester: random and directed runs against a memory slave model and a range-level reference
module tb_wb_mem_tester;
    localparam int AW = 23;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] addr_lo = '0;
    logic [AW-1:0] addr_hi = '0;
    logic [DW-1:0] seed = '0;
    logic          busy, done, pass, timeout;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr;
    logic [DW-1:0] first_err_data;

    wb_mem_tester_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    wb_mem_tester #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(15)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .addr_lo        (addr_lo),
        .addr_hi        (addr_hi),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .first_err_data (first_err_data),
        .wb             (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // slave model configuration (written only by the stimulus process)
    int lat = 5;
    int hold = 1;
    bit no_ack = 1'b0;
    bit flip [int];

    // slave model state and transfer logs (written only by the slave process)
    logic [DW-1:0] mem [int];
    int            wr_a [$];
    logic [DW-1:0] wr_d [$];
    int            rd_a [$];
    int            stb_rises = 0;
    int            early_rises = 0;
    int            cnt = 0;
    int            hold_left = 0;
    logic          stb_prev = 1'b0;
    bit            ack_low_seen = 1'b1;

    always @(negedge clk) begin : slave
        int a;
        if (rst) begin
            bus.ack_i    = 1'b0;
            bus.dat_i    = '0;
            cnt          = 0;
            hold_left    = 0;
            stb_prev     = 1'b0;
            ack_low_seen = 1'b1;
        end else begin
            if (bus.stb_o && !stb_prev) begin
                stb_rises++;
                if (!ack_low_seen) early_rises++;
            end
            stb_prev = bus.stb_o;
            if (!bus.ack_i) ack_low_seen = 1'b1;
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) bus.ack_i = 1'b0;
            end else if (bus.cyc_o && bus.stb_o && !no_ack) begin
                cnt++;
                if (cnt >= lat) begin
                    cnt          = 0;
                    bus.ack_i    = 1'b1;
                    hold_left    = hold;
                    ack_low_seen = 1'b0;
                    a            = int'(bus.addr_o);
                    if (bus.we_o) begin
                        wr_a.push_back(a);
                        wr_d.push_back(bus.dat_o);
                        mem[a] = bus.dat_o;
                    end else begin
                        rd_a.push_back(a);
                        bus.dat_i = (mem.exists(a) ? mem[a] : '0) ^ (flip.exists(a) ? 32'h1 : 32'h0);
                    end
                end
            end
        end
    end

    int wr_base, rd_base, rise_base;

    task automatic start_run(input string tag, input int lo, input int hi, input logic [DW-1:0] sd);
        wr_base   = wr_a.size();
        rd_base   = rd_a.size();
        rise_base = stb_rises;
        @(negedge clk);
        addr_lo = AW'(lo);
        addr_hi = AW'(hi);
        seed    = sd;
        start   = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".busy_t"}, busy, 1'b1);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, ".t1"}, lo <= hi ? bus.stb_o : done, 1'b0);
        @(posedge clk);
        #1;
        if (lo <= hi) check({tag, ".stb_t2"}, bus.stb_o, 1'b1);
        else begin
            check({tag, ".rng_done_t2"}, done, 1'b1);
            check({tag, ".rng_pass"}, pass, 1'b0);
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, ".done"}, done, 1'b1);
    endtask

    task automatic run_and_check(input string tag, input int lo, input int hi, input logic [DW-1:0] sd);
        int nw, exp_err, exp_fa;
        logic [DW-1:0] exp_fd;
        start_run(tag, lo, hi, sd);
        wait_done(tag, 20000);
        nw      = (lo <= hi) ? hi - lo + 1 : 0;
        exp_err = 0;
        exp_fa  = 0;
        exp_fd  = '0;
        for (int a = lo; a <= hi; a++) begin
            if (flip.exists(a)) begin
                if (exp_err == 0) begin
                    exp_fa = a;
                    exp_fd = (sd ^ DW'(a)) ^ 32'h1;
                end
                exp_err++;
            end
        end
        check({tag, ".nwr"}, wr_a.size() - wr_base, nw);
        check({tag, ".nrd"}, rd_a.size() - rd_base, nw);
        for (int i = 0; i < nw && wr_base + i < wr_a.size() && rd_base + i < rd_a.size(); i++) begin
            check({tag, ".wr_addr"}, wr_a[wr_base + i], lo + i);
            check({tag, ".wr_data"}, wr_d[wr_base + i], sd ^ DW'(lo + i));
            check({tag, ".rd_addr"}, rd_a[rd_base + i], lo + i);
        end
        check({tag, ".pass"}, pass, (lo <= hi) && exp_err == 0);
        check({tag, ".err_count"}, err_count, exp_err);
        check({tag, ".first_err_addr"}, first_err_addr, exp_fa);
        check({tag, ".first_err_data"}, first_err_data, exp_fd);
        check({tag, ".timeout"}, timeout, 1'b0);
        check({tag, ".busy"}, busy, 1'b0);
        if (lo > hi) check({tag, ".no_cyc"}, stb_rises - rise_base, 0);
    endtask

    initial begin
        int lo, hi, n, stb_hi;
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", busy, 1'b0);
        check("rst.done", done, 1'b0);
        check("rst.pass", pass, 1'b0);
        check("rst.timeout", timeout, 1'b0);
        check("rst.err_count", err_count, 16'h0);
        check("rst.first_err", {first_err_addr, first_err_data}, '0);
        check("rst.bus", {bus.cyc_o, bus.stb_o, bus.we_o, bus.addr_o, bus.dat_o}, '0);
        @(negedge clk);
        rst = 1'b0;

        run_and_check("basic", 0, 3, 32'hA5A50000);
        flip[2] = 1'b1;
        run_and_check("flip2", 0, 3, 32'hA5A50000);
        flip.delete();
        run_and_check("range_err", 5, 4, 32'h12345678);

        lat  = 2;
        hold = 2;
        run_and_check("ack2", 0, 1, 32'h0F0F0F0F);
        check("ack2.requests", stb_rises - rise_base, 4);
        check("ack2.early_stb", early_rises, 0);

        for (int it = 0; it < 8; it++) begin
            lat  = $urandom_range(1, 4);
            hold = $urandom_range(1, 3);
            lo   = (it == 7) ? 23'h7FFFFD : $urandom_range(0, 20);
            hi   = (it == 7) ? 23'h7FFFFF : lo + $urandom_range(0, 6);
            flip.delete();
            for (int a = lo; a <= hi; a++) if ($urandom_range(0, 3) == 0) flip[a] = 1'b1;
            run_and_check($sformatf("rand%0d", it), lo, hi, $urandom);
        end
        check("rand.early_stb", early_rises, 0);
        flip.delete();

        lat  = 3;
        hold = 1;
        start_run("midrst", 0, 7, 32'hC0DE0000);
        n = 0;
        while (!(rd_a.size() - rd_base == 2 && bus.stb_o) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("midrst.reached_rd3", n < 5000, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst.cyc_stb", {bus.cyc_o, bus.stb_o}, 2'b00);
        check("midrst.busy_done", {busy, done}, 2'b00);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_and_check("after_rst", 0, 7, 32'hC0DE0000);

        no_ack = 1'b1;
        start_run("noack", 0, 0, 32'h55AA55AA);
        stb_hi = 0;
`ifdef WB_MEM_TESTER_TIMEOUT_EN
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            if (bus.stb_o) stb_hi++;
            n++;
        end
        check("noack.done", done, 1'b1);
        check("noack.stb_within_16", stb_hi <= 16, 1'b1);
        check("noack.timeout", timeout, 1'b1);
        check("noack.pass", pass, 1'b0);
`else
        repeat (1000) begin
            @(posedge clk);
            #1;
            if (bus.stb_o) stb_hi++;
        end
        check("noack.stb_held", stb_hi, 1000);
        check("noack.busy", busy, 1'b1);
        check("noack.timeout", timeout, 1'b0);
`endif
        @(negedge clk);
        rst    = 1'b1;
        no_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("final.rst_stb", bus.stb_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
